crc32x64_check: RTL
===================

Name: crc32x64_check

Overview:
- Receive-side CRC checker for 64-bit word streams framed by the crc32x64 generator.
- Accumulates CRC-32 over a frame's payload words, then compares the result against the CRC carried in the frame's trailer word.
- Emits a one-cycle pass/fail result and keeps saturating good/bad frame counters.
- Sits after the link deframer, ahead of the packet consumer.

Parameters:
- COUNT_W, 32, width of good/bad frame counters.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high. Clears state, outputs and counters.
- ce  input  1  clock enable; when 0, every register holds.
- valid_in  input  1  data_in/sof_in/eof_in qualifier.
- sof_in  input  1  first word of frame (payload or trailer).
- eof_in  input  1  trailer word; data_in[31:0] = transmitted CRC, data_in[63:32] ignored.
- data_in  input  64  stream word; byte 0 = data_in[7:0], processed first.
- result_valid  output  1  one-cycle pulse: frame check complete.
- crc_ok  output  1  crc_calc == crc_rx; meaningful when result_valid=1.
- crc_calc  output  32  final computed CRC of the payload.
- crc_rx  output  32  CRC taken from the trailer word.
- framing_err  output  1  one-cycle pulse on protocol violation.
- good_count  output  COUNT_W  frames passing the check, saturating.
- bad_count  output  COUNT_W  frames failing the check or aborted, saturating.

Behaviour:
- CRC definition: reflected CRC-32 (poly 0xEDB88320, i.e. 0x04C11DB7 reversed).
  - Init 0xFFFFFFFF; final XOR 0xFFFFFFFF.
  - Bytes processed LSB-first from data_in[7:0] up to data_in[63:56].
  - One full 64-bit word absorbed per accepted cycle; no partial words.
- A word is accepted only when ce=1 and valid_in=1. All other cycles leave state unchanged.
- State machine, two states:
  - IDLE:
    - sof_in & !eof_in: go to IN_FRAME; crc_state = update(0xFFFFFFFF, data_in).
    - sof_in & eof_in: zero-payload frame. Check against 0x00000000; stay in IDLE.
    - eof_in & !sof_in: framing_err pulse; word dropped; no result; counters unchanged.
    - neither flag: word ignored silently.
  - IN_FRAME:
    - no flags: crc_state = update(crc_state, data_in).
    - eof_in & !sof_in: go to IDLE; crc_calc = crc_state ^ 0xFFFFFFFF, compared with data_in[31:0].
    - sof_in (with or without eof_in): framing_err pulse; aborted frame counts as bad_count+1 with no result_valid. The new frame then starts exactly as in IDLE, including the zero-payload case.
- Trailer word is never fed into the CRC.
- Result latency: result_valid, crc_ok, crc_calc and crc_rx are registered 1 ce-cycle after the trailer is accepted.
  - crc_calc/crc_rx/crc_ok hold until the next result.
  - result_valid and framing_err are high for exactly one ce-enabled cycle. If ce drops, they hold with the rest of the state; consumers qualify with ce.
- Counters: good_count++ on crc_ok result; bad_count++ on failing result or abort. Both saturate at all-ones and never wrap. Both update in the same cycle as result_valid.
- Simultaneous abort and zero-payload frame (sof&eof in IN_FRAME):
  - bad_count+1 for the abort, plus the zero-frame check.
  - The counter increments for the same event combine; bad may therefore increment by 2 in one cycle.
- Reset mid-frame: return to IDLE and discard the partial CRC. All outputs go to 0 on the cycle after rst, including counters, crc_calc, crc_rx and crc_ok.
- Throughput: one word per clock, no backpressure.

Test Plan:
- Single-payload frame, ascii "12345678" = 0x3837363534333231, then trailer 0x00000000_9AE0DAAF -> result_valid 1 cycle later, crc_calc=0x9AE0DAAF, crc_ok=1, good_count=1.
- Same frame with trailer CRC bit 0 flipped (0x9AE0DAAE) -> crc_ok=0, crc_rx=0x9AE0DAAE, bad_count=1, good_count unchanged.
- Payload 0x0000000000000000 with trailer 0x6522DF69 -> ok. Zero-payload frame (sof&eof, data 0) -> ok, crc_calc=0x00000000.
- Abort and stray trailer:
  - sof mid-frame -> framing_err pulse, bad_count+1, new frame checks correctly.
  - eof in IDLE -> framing_err only, counters unchanged.
- Stream gaps and clock-enable gating:
  - valid_in toggled low between payload words -> result identical to a gapless stream.
  - ce=0 for 3 cycles mid-frame -> all outputs frozen, result identical.
- Reset and saturation:
  - rst asserted mid-frame, then a good frame -> counters 0 after rst, then good_count=1.
  - COUNT_W=2 with 5 good frames -> good_count sticks at 3.

Source files
------------

// File: rtl/crc32x64_check.sv
// crc32x64_check: receive-side CRC-32 checker for 64-bit framed word streams.
//
// Accumulates reflected CRC-32 (poly 0xEDB88320, init/xorout 0xFFFFFFFF) over
// a frame's payload words, then compares it with the CRC in the trailer word.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ce                clock enable; every register holds while low
//   valid_in          qualifies sof_in/eof_in/data_in
//   sof_in, eof_in    frame start / trailer markers
//   data_in[63:0]     stream word, byte 0 in [7:0]; trailer carries CRC in [31:0]
//   result_valid      one-cycle pulse when a frame check completes
//   crc_ok            crc_calc == crc_rx, held until the next result
//   crc_calc, crc_rx  computed and received CRC, held until the next result
//   framing_err       one-cycle pulse on protocol violation
//   good_count        saturating count of passing frames
//   bad_count         saturating count of failing or aborted frames
module crc32x64_check #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               valid_in,
  input  logic               sof_in,
  input  logic               eof_in,
  input  logic [63:0]        data_in,
  output logic               result_valid,
  output logic               crc_ok,
  output logic [31:0]        crc_calc,
  output logic [31:0]        crc_rx,
  output logic               framing_err,
  output logic [COUNT_W-1:0] good_count,
  output logic [COUNT_W-1:0] bad_count
);

  typedef enum logic [0:0] {StIdle, StInFrame} state_e;

  localparam logic [31:0]        CrcInit = 32'hFFFF_FFFF;
  localparam logic [31:0]        CrcPoly = 32'hEDB8_8320;
  localparam logic [COUNT_W+1:0] CntMax  = {2'b00, {COUNT_W{1'b1}}};

  // Absorb one 64-bit word, bit 0 first (bytes LSB-first, reflected CRC).
  function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [63:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 64; i++) begin
      c = {1'b0, c[31:1]} ^ (CrcPoly & {32{c[0] ^ data[i]}});
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        crc_state_q, crc_state_d;
  logic               result_valid_q, result_valid_d;
  logic               crc_ok_q, crc_ok_d;
  logic [31:0]        crc_calc_q, crc_calc_d;
  logic [31:0]        crc_rx_q, crc_rx_d;
  logic               framing_err_q, framing_err_d;
  logic [COUNT_W-1:0] good_q, good_d;
  logic [COUNT_W-1:0] bad_q, bad_d;
  logic [1:0]         good_inc, bad_inc;
  logic [COUNT_W+1:0] good_sum, bad_sum;
  logic               start;

  always_comb begin
    state_d        = state_q;
    crc_state_d    = crc_state_q;
    result_valid_d = 1'b0;
    framing_err_d  = 1'b0;
    crc_ok_d       = crc_ok_q;
    crc_calc_d     = crc_calc_q;
    crc_rx_d       = crc_rx_q;
    good_inc       = 2'd0;
    bad_inc        = 2'd0;
    start          = 1'b0;

    if (valid_in) begin
      unique case (state_q)
        StIdle: begin
          start = sof_in;
          if (eof_in && !sof_in) framing_err_d = 1'b1;
        end
        StInFrame: begin
          if (sof_in) begin
            // Abort: count the lost frame, then restart on this word.
            framing_err_d = 1'b1;
            bad_inc       = 2'd1;
            start         = 1'b1;
          end else if (eof_in) begin
            state_d        = StIdle;
            result_valid_d = 1'b1;
            crc_calc_d     = crc_state_q ^ CrcInit;
            crc_rx_d       = data_in[31:0];
            crc_ok_d       = ((crc_state_q ^ CrcInit) == data_in[31:0]);
          end else begin
            crc_state_d = crc_update(crc_state_q, data_in);
          end
        end
        default: state_d = StIdle;
      endcase

      if (start) begin
        if (eof_in) begin
          // Zero-payload frame: CRC of nothing is init ^ xorout = 0.
          state_d        = StIdle;
          result_valid_d = 1'b1;
          crc_calc_d     = 32'h0;
          crc_rx_d       = data_in[31:0];
          crc_ok_d       = (data_in[31:0] == 32'h0);
        end else begin
          state_d     = StInFrame;
          crc_state_d = crc_update(CrcInit, data_in);
        end
      end

      if (result_valid_d) begin
        if (crc_ok_d) good_inc = 2'd1;
        else          bad_inc  = bad_inc + 2'd1;
      end
    end

    good_sum = {2'b00, good_q} + {{COUNT_W{1'b0}}, good_inc};
    bad_sum  = {2'b00, bad_q} + {{COUNT_W{1'b0}}, bad_inc};
    good_d   = (good_sum > CntMax) ? {COUNT_W{1'b1}} : good_sum[COUNT_W-1:0];
    bad_d    = (bad_sum > CntMax) ? {COUNT_W{1'b1}} : bad_sum[COUNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      crc_state_q    <= CrcInit;
      result_valid_q <= 1'b0;
      crc_ok_q       <= 1'b0;
      crc_calc_q     <= 32'h0;
      crc_rx_q       <= 32'h0;
      framing_err_q  <= 1'b0;
      good_q         <= '0;
      bad_q          <= '0;
    end else if (ce) begin
      state_q        <= state_d;
      crc_state_q    <= crc_state_d;
      result_valid_q <= result_valid_d;
      crc_ok_q       <= crc_ok_d;
      crc_calc_q     <= crc_calc_d;
      crc_rx_q       <= crc_rx_d;
      framing_err_q  <= framing_err_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
    end
  end

  assign result_valid = result_valid_q;
  assign crc_ok       = crc_ok_q;
  assign crc_calc     = crc_calc_q;
  assign crc_rx       = crc_rx_q;
  assign framing_err  = framing_err_q;
  assign good_count   = good_q;
  assign bad_count    = bad_q;

endmodule
